// File: rtl/stepper_move_ctrl_pkg.sv
// rtl/stepper_move_ctrl_pkg.sv - shared constants and state encoding for the stepper move controller
//
// Contents:
//   POS_W_DEF       default position / step-count width
//   HOME_STEPS_DEF  default step budget issued during homing
//   MAX_POS_DEF     default highest legal position (soft-limit build only)
//   COIL_FWD/BWD    coil-state mux select values shared with the drivers
//   state_t         controller state encoding
package stepper_move_ctrl_pkg;

    localparam int         POS_W_DEF      = 12;
    localparam logic [11:0] HOME_STEPS_DEF = 12'hFFF;
    localparam logic [11:0] MAX_POS_DEF    = 12'd3000;

    localparam logic COIL_FWD = 1'b0;
    localparam logic COIL_BWD = 1'b1;

    typedef enum logic [2:0] {
        ST_RST     = 3'd0,
        ST_IDLE    = 3'd1,
        ST_CALC    = 3'd2,
        ST_RUN_F   = 3'd3,
        ST_RUN_B   = 3'd4,
        ST_RELEASE = 3'd5,
        ST_HOME    = 3'd6
    } state_t;

endpackage

// File: rtl/stepper_move_ctrl_delta.sv
// rtl/stepper_move_ctrl_delta.sv - combinational direction / step-count calculation
//
// Ports:
//   target    in   POS_W  absolute target position
//   position  in   POS_W  current tracked position
//   go_fwd    out  1      target lies above position
//   go_bwd    out  1      target lies below position
//   delta     out  POS_W  unsigned distance, zero when equal
module stepper_move_ctrl_delta #(
    parameter int POS_W = 12
) (
    input  logic [POS_W-1:0] target,
    input  logic [POS_W-1:0] position,
    output logic             go_fwd,
    output logic             go_bwd,
    output logic [POS_W-1:0] delta
);

    // Compare first so the subtraction picks the operand order that cannot underflow.
    always_comb begin
        go_fwd = (target > position);
        go_bwd = (target < position);
        delta  = '0;
        if (go_fwd) begin
            delta = target - position;
        end else if (go_bwd) begin
            delta = position - target;
        end
    end

endmodule

// File: rtl/stepper_move_ctrl.sv
// rtl/stepper_move_ctrl.sv - go/steps/done initiator for one axis of fwd/bwd stepper drivers
//
// Optional feature: define STEPPER_SOFT_LIMIT_EN to clamp targets to MAX_POS
// and reject moves while the axis is not homed.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   cmd_valid/cmd_ready  command handshake (accepted when both high)
//   cmd_home             1 = homing command, 0 = move to cmd_target
//   cmd_target           absolute target position
//   fwd_go/bwd_go        go to the forward / backward driver
//   steps                step count presented to both drivers
//   dir_bwd              coil mux select, 1 = backward driver owns the coils
//   fwd_done/bwd_done    driver completion
//   boundary             limit switch (already synchronised)
//   position             tracked axis position
//   homed                position valid since last successful homing
//   err                  sticky error, cleared on the next accepted command
module stepper_move_ctrl
    import stepper_move_ctrl_pkg::*;
#(
    parameter int               POS_W      = POS_W_DEF,
    parameter logic [POS_W-1:0] HOME_STEPS = HOME_STEPS_DEF,
    parameter logic [POS_W-1:0] MAX_POS    = MAX_POS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic             cmd_home,
    input  logic [POS_W-1:0] cmd_target,
    output logic             cmd_ready,
    output logic             fwd_go,
    output logic             bwd_go,
    output logic [POS_W-1:0] steps,
    output logic             dir_bwd,
    input  logic             fwd_done,
    input  logic             bwd_done,
    input  logic             boundary,
    output logic [POS_W-1:0] position,
    output logic             homed,
    output logic             err
);

    state_t           state, state_nx;
    logic [POS_W-1:0] target_q;
    logic [POS_W-1:0] eff_target;
    logic             move_ok;
    logic             calc_fwd, calc_bwd;
    logic [POS_W-1:0] calc_delta;

`ifdef STEPPER_SOFT_LIMIT_EN
    assign eff_target = (target_q > MAX_POS) ? MAX_POS : target_q;
    assign move_ok    = homed;
`else
    assign eff_target = target_q;
    assign move_ok    = 1'b1;
`endif

    stepper_move_ctrl_delta #(
        .POS_W    (POS_W)
    ) u_delta (
        .target   (eff_target),
        .position (position),
        .go_fwd   (calc_fwd),
        .go_bwd   (calc_bwd),
        .delta    (calc_delta)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RST;
        end else begin
            state <= state_nx;
        end
    end

    // Go outputs decode straight from the state register, so reset drops
    // them without waiting for a clock edge.
    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        fwd_go    = 1'b0;
        bwd_go    = 1'b0;
        case (state)
            ST_RST: begin
                state_nx = ST_IDLE;
            end
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nx = cmd_home ? ST_HOME : ST_CALC;
                end
            end
            ST_CALC: begin
                if (!move_ok) begin
                    state_nx = ST_IDLE;
                end else if (calc_fwd) begin
                    state_nx = ST_RUN_F;
                end else if (calc_bwd) begin
                    state_nx = ST_RUN_B;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_RUN_F: begin
                fwd_go = 1'b1;
                if (fwd_done) begin
                    state_nx = ST_RELEASE;
                end
            end
            ST_RUN_B: begin
                bwd_go = 1'b1;
                if (bwd_done) begin
                    state_nx = ST_RELEASE;
                end
            end
            ST_HOME: begin
                bwd_go = 1'b1;
                if (bwd_done) begin
                    state_nx = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                // One cycle with both go low lets the driver clear done and its counter.
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target_q <= '0;
            steps    <= '0;
            dir_bwd  <= COIL_FWD;
            position <= '0;
            homed    <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        err <= 1'b0;
                        if (cmd_home) begin
                            steps   <= HOME_STEPS;
                            dir_bwd <= COIL_BWD;
                        end else begin
                            target_q <= cmd_target;
                        end
                    end
                end
                ST_CALC: begin
                    // Keep the clamped target so the final position matches the steps issued.
                    target_q <= eff_target;
                    if (!move_ok) begin
                        err <= 1'b1;
                    end else if (calc_fwd) begin
                        steps   <= calc_delta;
                        dir_bwd <= COIL_FWD;
                    end else if (calc_bwd) begin
                        steps   <= calc_delta;
                        dir_bwd <= COIL_BWD;
                    end
                end
                ST_RUN_F, ST_RUN_B: begin
                    if ((state == ST_RUN_F) ? fwd_done : bwd_done) begin
                        if (boundary) begin
                            // Move stopped short at the limit: true position unknown.
                            err   <= 1'b1;
                            homed <= 1'b0;
                        end else begin
                            position <= target_q;
                        end
                    end
                end
                ST_HOME: begin
                    if (bwd_done) begin
                        if (boundary) begin
                            position <= '0;
                            homed    <= 1'b1;
                        end else begin
                            err   <= 1'b1;
                            homed <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// tb/tb_stepper_move_ctrl.sv - self-checking bench for stepper_move_ctrl (default build)
module tb_stepper_move_ctrl;

    localparam int W = 12;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_home;
    logic [W-1:0] cmd_target;
    logic         cmd_ready;
    logic         fwd_go;
    logic         bwd_go;
    logic [W-1:0] steps;
    logic         dir_bwd;
    logic         fwd_done;
    logic         bwd_done;
    logic         boundary;
    logic [W-1:0] position;
    logic         homed;
    logic         err;

    int checks = 0;
    int errors = 0;

    // Driver / limit-switch model
    int cnt = 0;
    int bnd_at;
    bit bnd_static;
    bit inj_bwd;

    always #5 clk = ~clk;

    always @(posedge clk) cnt <= (fwd_go || bwd_go) ? cnt + 1 : 0;

    assign boundary = bnd_static || (bnd_at > 0 && cnt >= bnd_at);
    assign fwd_done = fwd_go && (cnt >= int'(steps) || boundary);
    assign bwd_done = (bwd_go && (cnt >= int'(steps) || boundary)) || inj_bwd;

    stepper_move_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_home   (cmd_home),
        .cmd_target (cmd_target),
        .cmd_ready  (cmd_ready),
        .fwd_go     (fwd_go),
        .bwd_go     (bwd_go),
        .steps      (steps),
        .dir_bwd    (dir_bwd),
        .fwd_done   (fwd_done),
        .bwd_done   (bwd_done),
        .boundary   (boundary),
        .position   (position),
        .homed      (homed),
        .err        (err)
    );

    typedef struct {
        bit           home;
        logic [W-1:0] target;
        int           bnd_at;
        bit           bnd_static;
        bit           exp_f;
        bit           exp_b;
        logic [W-1:0] exp_steps;
        bit           exp_dir;
        logic [W-1:0] exp_pos;
        bit           exp_homed;
        bit           exp_err;
    } vec_t;

    vec_t vecs[10];
    vec_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL wait_ready: cmd_ready still 0 after %0d cycles", budget);
        end
    endtask

    task automatic wait_fwd_go(input int budget);
        int n = 0;
        while (!fwd_go && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!fwd_go) begin
            checks++;
            errors++;
            $display("FAIL wait_fwd_go: fwd_go still 0 after %0d cycles", budget);
        end
    endtask

    // Called at a negedge with cmd_ready high; returns #1 after the accepting edge.
    task automatic issue(input bit home, input logic [W-1:0] target);
        cmd_valid  = 1'b1;
        cmd_home   = home;
        cmd_target = target;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_home  = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        vec_t         e;
        int           k;
        int           done_k;
        int           ready_k;
        bit           saw_f, saw_b, both, chg, first;
        logic [W-1:0] st;
        logic         d;
        wait_ready(200);
        bnd_at     = v.bnd_at;
        bnd_static = v.bnd_static;
        issue(v.home, v.target);
        sb.push_back(v);
        k = 0; done_k = -1; ready_k = -1;
        saw_f = 0; saw_b = 0; both = 0; chg = 0; first = 1;
        st = '0; d = 1'b0;
        while (k < 6000) begin
            @(negedge clk);
            k++;
            if (k == 1) chk("err_clear_on_accept", err, 0);
            if (fwd_go && bwd_go) both = 1;
            if (fwd_go || bwd_go) begin
                if (first) begin
                    st = steps;
                    d = dir_bwd;
                    first = 0;
                end else if (steps !== st) begin
                    chg = 1;
                end
            end
            if (fwd_go) saw_f = 1;
            if (bwd_go) saw_b = 1;
            if ((fwd_go && fwd_done) || (bwd_go && bwd_done)) done_k = k;
            if (cmd_ready) begin
                ready_k = k;
                break;
            end
        end
        if (ready_k < 0) begin
            checks++;
            errors++;
            $display("FAIL cmd_timeout: cmd_ready not back within %0d cycles", k);
        end
        e = sb.pop_front();
        chk("fwd_go_seen", saw_f, e.exp_f);
        chk("bwd_go_seen", saw_b, e.exp_b);
        chk("go_exclusive", both, 0);
        if (e.exp_f || e.exp_b) begin
            chk("steps", st, e.exp_steps);
            chk("dir_bwd", d, e.exp_dir);
            chk("steps_stable", chg, 0);
            chk("done_to_ready", ready_k - done_k, 2);
        end else begin
            chk("accept_to_ready", ready_k, 2);
        end
        chk("position", position, e.exp_pos);
        chk("homed", homed, e.exp_homed);
        chk("err", err, e.exp_err);
        bnd_at     = 0;
        bnd_static = 0;
    endtask

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_home   = 1'b0;
        cmd_target = '0;
        bnd_at     = 0;
        bnd_static = 1'b0;
        inj_bwd    = 1'b0;

        // home, target, bnd_at, bnd_static, f, b, steps, dir, pos, homed, err
        vecs[0] = '{1'b1, 12'd0,    40,  1'b0, 1'b0, 1'b1, 12'hFFF, 1'b1, 12'd0,    1'b1, 1'b0};
        vecs[1] = '{1'b0, 12'd100,  0,   1'b0, 1'b1, 1'b0, 12'd100, 1'b0, 12'd100,  1'b1, 1'b0};
        vecs[2] = '{1'b0, 12'd30,   0,   1'b0, 1'b0, 1'b1, 12'd70,  1'b1, 12'd30,   1'b1, 1'b0};
        vecs[3] = '{1'b0, 12'd30,   0,   1'b0, 1'b0, 1'b0, 12'd0,   1'b0, 12'd30,   1'b1, 1'b0};
        vecs[4] = '{1'b0, 12'd500,  200, 1'b0, 1'b1, 1'b0, 12'd470, 1'b0, 12'd30,   1'b0, 1'b1};
        vecs[5] = '{1'b0, 12'd10,   0,   1'b0, 1'b0, 1'b1, 12'd20,  1'b1, 12'd10,   1'b0, 1'b0};
        vecs[6] = '{1'b1, 12'd0,    0,   1'b0, 1'b0, 1'b1, 12'hFFF, 1'b1, 12'd10,   1'b0, 1'b1};
        vecs[7] = '{1'b1, 12'd0,    0,   1'b1, 1'b0, 1'b1, 12'hFFF, 1'b1, 12'd0,    1'b1, 1'b0};
        vecs[8] = '{1'b0, 12'd4095, 0,   1'b0, 1'b1, 1'b0, 12'd4095, 1'b0, 12'd4095, 1'b1, 1'b0};
        vecs[9] = '{1'b0, 12'd0,    0,   1'b0, 1'b0, 1'b1, 12'd4095, 1'b1, 12'd0,    1'b1, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_fwd_go", fwd_go, 0);
        chk("rst_bwd_go", bwd_go, 0);
        chk("rst_steps", steps, 0);
        chk("rst_dir_bwd", dir_bwd, 0);
        chk("rst_position", position, 0);
        chk("rst_homed", homed, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        #1;
        chk("rst_release_ready_low", cmd_ready, 0);
        @(negedge clk);
        chk("rst_release_ready_high", cmd_ready, 1);

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i]);
        end

        // Foreign done and commands during a move are ignored.
        wait_ready(200);
        issue(1'b0, 12'd50);
        wait_fwd_go(10);
        repeat (5) @(negedge clk);
        inj_bwd    = 1'b1;
        cmd_valid  = 1'b1;
        cmd_home   = 1'b1;
        cmd_target = 12'd7;
        repeat (3) @(negedge clk);
        chk("ignore_bwd_done_fwd_go", fwd_go, 1);
        chk("ignore_bwd_done_bwd_go", bwd_go, 0);
        inj_bwd   = 1'b0;
        cmd_valid = 1'b0;
        cmd_home  = 1'b0;
        wait_ready(200);
        chk("ignore_pos", position, 50);
        repeat (3) @(negedge clk);
        chk("no_queued_cmd_ready", cmd_ready, 1);
        chk("no_queued_cmd_pos", position, 50);
        chk("no_queued_cmd_steps", steps, 50);

        // Reset in the middle of a forward move.
        issue(1'b0, 12'd200);
        wait_fwd_go(10);
        repeat (10) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_fwd_go", fwd_go, 0);
        chk("midrst_position", position, 0);
        chk("midrst_homed", homed, 0);
        chk("midrst_ready", cmd_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_release_ready_low", cmd_ready, 0);
        @(negedge clk);
        chk("midrst_release_ready_high", cmd_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stepper_move_ctrl.md
Name: stepper_move_ctrl

Overview:
- Initiator side of the stepper go/steps/done handshake: accepts absolute-position move commands and homing commands.
- Computes direction and step count, then drives the forward or backward stepper driver.
- Waits for that driver's done, then updates the tracked axis position.
- Sits between the board-level command logic and one axis pair of forward/backward stepper drivers; one instance per axis.

Parameters:
- POS_W, 12, width of position and step count (matches the driver steps input).
- HOME_STEPS, 12'hFFF, step budget issued during homing before declaring failure.
- MAX_POS, 12'd3000, highest legal position (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request; accepted when cmd_valid && cmd_ready
- cmd_home  in  1  with cmd_valid: 1 = homing command, 0 = move to cmd_target
- cmd_target  in  POS_W  absolute target position
- cmd_ready  out  1  controller idle and able to accept a command
- fwd_go  out  1  go to the forward driver
- bwd_go  out  1  go to the backward driver
- steps  out  POS_W  step count presented to both drivers
- dir_bwd  out  1  coil-state mux select: 1 = backward driver owns the coils
- fwd_done  in  1  forward driver done
- bwd_done  in  1  backward driver done
- boundary  in  1  limit switch, active-high, asynchronous to moves (already synchronised upstream)
- position  out  POS_W  current tracked position
- homed  out  1  position valid since the last successful homing
- err  out  1  sticky: the last move hit the boundary, or homing ran out of steps

Behaviour:
- Reset values: cmd_ready=0 for one cycle (state RST→IDLE), then 1. fwd_go=0, bwd_go=0, steps=0, dir_bwd=0, position=0, homed=0, err=0.
- States: IDLE, CALC, RUN_F, RUN_B, RELEASE, HOME.
- IDLE: cmd_ready=1.
  - On accept with cmd_home=1: go to HOME.
  - On accept otherwise: latch target, go to CALC. err is cleared on any accept.
- CALC (1 cycle):
  - target > position: steps = target - position, dir_bwd=0, go to RUN_F.
  - target < position: steps = position - target, dir_bwd=1, go to RUN_B.
  - Equal: go straight to IDLE with no go pulse.
  - Subtraction is unsigned in POS_W bits and never underflows because the comparison is done first.
- RUN_F / RUN_B: hold the matching go high and hold steps stable; wait for that driver's done.
  - On done with boundary low: position <= target.
  - On done with boundary high: position is unknown; set err=1 and homed=0, position unchanged.
  - Then go to RELEASE.
- HOME: dir_bwd=1, steps=HOME_STEPS, bwd_go=1.
  - On bwd_done with boundary high: position <= 0, homed <= 1.
  - On bwd_done with boundary low: err <= 1, homed <= 0.
  - Then go to RELEASE.
- RELEASE: both go signals low for exactly 1 cycle so the driver clears its done and step counter, then IDLE. Latency from done to cmd_ready is 2 cycles.
- Never assert fwd_go and bwd_go together. dir_bwd changes only in CALC, HOME entry, or reset.
- A done from the non-selected driver is ignored.
- cmd_valid outside IDLE is ignored (not queued).
- Boundary already high at a move start: the driver reports done immediately, giving err=1 after RUN. Homing with boundary already high completes with position=0.
- rst mid-move: all go signals drop asynchronously, and position and homed are lost (homed=0).

Optional Feature:
- Macro STEPPER_SOFT_LIMIT_EN.
- Defined: in CALC, a cmd_target above MAX_POS is clamped to MAX_POS before the step computation. A move commanded while homed=0 is rejected (err=1, return to IDLE, no go pulse).
- Undefined: no clamping and no homed check; the full POS_W range is accepted.

Decomposition:
- Shared package: state encoding constants, POS_W default, HOME_STEPS default, and the coil-state constants shared with the drivers.
- No sub-module is needed. One natural optional split is stepper_delta_calc, the combinational compare/subtract used in CALC.

Test Plan:
- Reset, then home: cmd_home=1; boundary raised after 40 bwd steps; bwd_done pulses → position=0, homed=1, err=0, cmd_ready returns 2 cycles after done.
- From position 0, cmd_target=100 → CALC gives steps=100, dir_bwd=0, fwd_go held until fwd_done → position=100, bwd_go never high.
- From 100, cmd_target=30 → steps=70, dir_bwd=1, bwd_go → position=30. Then cmd_target=30 → no go pulse, cmd_ready back after 2 cycles.
- Move 30→500 with boundary asserted mid-move, driver returns done early → err=1, homed=0, position stays 30. The next accepted command clears err.
- Homing where boundary never rises, driver completes 4095 steps → err=1, homed=0. rst asserted during RUN_F → fwd_go=0 immediately, position=0.
- With STEPPER_SOFT_LIMIT_EN: homed=1, cmd_target=4000 → steps=MAX_POS-position. With homed=0, any move → err=1 and no go pulse.
